hex_display_scanner: RTL and testbench

HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

---
 rtl/hex_display_scanner_if.sv | 22 ++
 rtl/hex_display_scanner.sv | 144 ++++++++++++++
 tb/tb_hex_display_scanner.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_scanner_if.sv
// Display-side bundle of the hex scanner: word to show plus the LED drive pins.
interface hex_display_scanner_if;
  logic [15:0] value;
  logic        value_valid;
  logic        lz_toggle;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_start;

  // Driver of the word and owner of the pins (board / bench side)
  modport master (
    output value, value_valid, lz_toggle,
    input  seg_n, an_n, dp_n, frame_start
  );

  // Scanner side
  modport slave (
    input  value, value_valid, lz_toggle,
    output seg_n, an_n, dp_n, frame_start
  );
endinterface

// File: rtl/hex_display_scanner.sv
// Four-digit multiplexed hex display scanner.
// A whole 16-bit word is captured once per frame (at the digit 3 -> 0 step) so a
// frame never mixes two words. Digit enable and segment pattern come out of the
// same register stage, so no digit ever shows a neighbour's pattern.
module hex_display_scanner #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LZ_DEFAULT  = 1'b0
) (
  input  logic                   clock,
  input  logic                   resetn,
  hex_display_scanner_if.slave   bus
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_snap;
  logic          r_snap_valid;
  logic          r_lz_pend;     // toggled by lz_toggle, applied at next snapshot
  logic          r_lz_act;      // suppression state of the frame on display
  logic          r_frame_start;
  logic [3:0]    r_an_n;
  logic [6:0]    r_seg_n;

  logic          w_tick;
  logic          w_snap_tick;
  logic [3:0]    w_nib;
  logic          w_upper_zero;
  logic          w_blank;
  logic [6:0]    w_seg_n;
  logic [3:0]    w_an_n;

  assign w_tick      = (r_cnt == CNT_LAST);
  assign w_snap_tick = w_tick && (r_idx == 2'd3);
  assign w_nib       = r_snap[{r_idx, 2'b00} +: 4];

  // Refresh counter: 0..REFRESH_DIV-1, wraps on tick
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)      r_cnt <= '0;
    else if (w_tick)  r_cnt <= '0;
    else              r_cnt <= r_cnt + CW'(1);
  end

  // Digit index steps once per tick
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)      r_idx <= 2'd0;
    else if (w_tick)  r_idx <= r_idx + 2'd1;
  end

  // Frame snapshot of the word and its validity
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_snap       <= 16'h0000;
      r_snap_valid <= 1'b0;
    end else if (w_snap_tick) begin
      r_snap       <= bus.value;
      r_snap_valid <= bus.value_valid;
    end
  end

  // Suppression: toggles land in the pending copy; the snapshot promotes the
  // pending value as it stood before this cycle, so a toggle coincident with
  // the snapshot only shows up one frame later.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_lz_pend <= LZ_DEFAULT;
      r_lz_act  <= LZ_DEFAULT;
    end else begin
      r_lz_pend <= r_lz_pend ^ bus.lz_toggle;
      if (w_snap_tick) r_lz_act <= r_lz_pend;
    end
  end

  // frame_start marks the cycle after a snapshot
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_frame_start <= 1'b0;
    else         r_frame_start <= w_snap_tick;
  end

  // Are all nibbles from the current digit upward zero (digit 0 never counts)
  always_comb begin
    w_upper_zero = 1'b0;
    case (r_idx)
      2'd1:    w_upper_zero = (r_snap[15:4]  == 12'h000);
      2'd2:    w_upper_zero = (r_snap[15:8]  == 8'h00);
      2'd3:    w_upper_zero = (r_snap[15:12] == 4'h0);
      default: w_upper_zero = 1'b0;
    endcase
  end

  assign w_blank = !r_snap_valid || (r_lz_act && w_upper_zero);

  // Hex glyph decode, {g,f,e,d,c,b,a} active-low
  always_comb begin
    w_seg_n = 7'h7F;
    case (w_nib)
      4'h0: w_seg_n = ~7'h3F;
      4'h1: w_seg_n = ~7'h06;
      4'h2: w_seg_n = ~7'h5B;
      4'h3: w_seg_n = ~7'h4F;
      4'h4: w_seg_n = ~7'h66;
      4'h5: w_seg_n = ~7'h6D;
      4'h6: w_seg_n = ~7'h7D;
      4'h7: w_seg_n = ~7'h07;
      4'h8: w_seg_n = ~7'h7F;
      4'h9: w_seg_n = ~7'h6F;
      4'hA: w_seg_n = ~7'h77;
      4'hB: w_seg_n = ~7'h7C;
      4'hC: w_seg_n = ~7'h39;
      4'hD: w_seg_n = ~7'h5E;
      4'hE: w_seg_n = ~7'h79;
      4'hF: w_seg_n = ~7'h71;
      default: w_seg_n = 7'h7F;
    endcase
  end

  // One-hot-low enable for the current digit
  always_comb begin
    w_an_n        = 4'hF;
    w_an_n[r_idx] = 1'b0;
  end

  // Enable and pattern registered together; a blanked digit also drops segments
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_an_n  <= 4'hF;
      r_seg_n <= 7'h7F;
    end else if (w_blank) begin
      r_an_n  <= 4'hF;
      r_seg_n <= 7'h7F;
    end else begin
      r_an_n  <= w_an_n;
      r_seg_n <= w_seg_n;
    end
  end

  assign bus.an_n        = r_an_n;
  assign bus.seg_n       = r_seg_n;
  assign bus.dp_n        = 1'b1;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: frame-level model plus directed literal frames.
module tb_hex_display_scanner;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;
  localparam bit LZD   = 1'b0;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  hex_display_scanner_if bus();

  hex_display_scanner #(.REFRESH_DIV(DIV), .LZ_DEFAULT(LZD)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Glyphs as the lit-segment letters; converted to an active-low mask.
  string shapes[16] = '{"abcdef","bc","abdeg","abcdg","bcfg","acdfg","acdefg","abc",
                        "abcdefg","abcdfg","abcefg","cdefg","adef","bcdeg","adefg","aefg"};

  function automatic logic [6:0] glyph_n(input string s);
    logic [6:0] m;
    m = '0;
    for (int i = 0; i < s.len(); i++) m[int'(s[i]) - 97] = 1'b1;
    return ~m;
  endfunction

  typedef struct {
    logic [15:0] v;
    logic        ok;
    bit          lz;
  } snap_t;

  snap_t       q[$];
  int unsigned n = 0;        // rising edges since reset release
  bit          p = LZD;      // pending suppression state
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_fs = 1'b0;
  bit          seg_care = 1'b1;

  // Edge n: every FRAME-th edge captures a frame; outputs after edge n show the
  // digit the scan was on during cycle n-1, from the frame captured before that.
  initial forever begin
    @(posedge clock or negedge resetn);
    if (!resetn) begin
      n = 0; p = LZD; q.delete();
      e_an = 4'hF; e_seg = 7'h7F; e_fs = 1'b0; seg_care = 1'b1;
    end else begin
      int k, fr, dg;
      snap_t s;
      n++;
      e_fs = ((n % FRAME) == 0);
      if (e_fs) q.push_back('{bus.value, bus.value_valid, p});
      if (bus.lz_toggle) p = ~p;
      k  = int'(n) - 1;
      fr = k / FRAME;
      dg = (k / DIV) % 4;
      e_an = 4'hF; e_seg = 7'h7F; seg_care = 1'b1;
      if (fr > 0) begin
        s = q[fr-1];
        if (s.ok) begin
          if (s.lz && dg > 0 && (s.v >> (4*dg)) == 0) seg_care = 1'b0;
          else begin
            e_an[dg] = 1'b0;
            e_seg = glyph_n(shapes[(s.v >> (4*dg)) & 16'hF]);
          end
        end
      end
    end
  end

  // Per-cycle compare plus structural invariants
  logic prev_fs = 1'b0;
  initial forever begin
    @(negedge clock);
    chk("an_n", {12'h0, bus.an_n}, {12'h0, e_an});
    if (seg_care) chk("seg_n", {9'h0, bus.seg_n}, {9'h0, e_seg});
    chk("frame_start", {15'h0, bus.frame_start}, {15'h0, e_fs});
    chk("dp_n", {15'h0, bus.dp_n}, 16'h1);
    chk("an_shape", {15'h0, (bus.an_n == 4'hF) || $onehot(~bus.an_n)}, 16'h1);
    chk("fs_back_to_back", {15'h0, prev_fs && bus.frame_start}, 16'h0);
    prev_fs = bus.frame_start;
  end

  // ---------------- directed helpers ----------------
  task automatic wait_fs(output int c);
    c = 0;
    do begin
      @(negedge clock);
      c++;
    end while (!bus.frame_start && c < 8 * FRAME);
    chk("fs_timeout", {15'h0, bus.frame_start}, 16'h1);
  endtask

  // Called right at the negedge where frame_start is seen; checks the start of each digit.
  task automatic chk_frame(input string name, input logic [3:0][3:0] an_e,
                           input logic [3:0][6:0] seg_e, input logic [3:0] care);
    for (int d = 0; d < 4; d++) begin
      if (d == 0) @(negedge clock);
      else repeat (DIV) @(negedge clock);
      chk({name, "_an"}, {12'h0, bus.an_n}, {12'h0, an_e[d]});
      if (care[d]) chk({name, "_seg"}, {9'h0, bus.seg_n}, {9'h0, seg_e[d]});
    end
  endtask

  initial begin
    int c;
    bus.value = 16'h0; bus.value_valid = 1'b0; bus.lz_toggle = 1'b0;
    repeat (3) @(negedge clock);
    #2 resetn = 1'b1;

    // first snapshot is the FRAME-th edge after release -> seen at the FRAME-th falling edge
    bus.value = 16'h1A3F; bus.value_valid = 1'b1;
    wait_fs(c);
    chk("first_fs_latency", 16'(c), 16'(FRAME));
    chk_frame("f_1A3F", {4'h7,4'hB,4'hD,4'hE}, {7'h79,7'h08,7'h30,7'h0E}, 4'hF);
    wait_fs(c);
    wait_fs(c);
    chk("frame_period", 16'(c), 16'(FRAME));

    // word changes mid-frame: current frame stays 1234
    bus.value = 16'h1234;
    wait_fs(c);
    bus.value = 16'hBEEF;
    chk_frame("f_1234", {4'h7,4'hB,4'hD,4'hE}, {7'h79,7'h24,7'h30,7'h19}, 4'hF);
    wait_fs(c);
    chk_frame("f_BEEF", {4'h7,4'hB,4'hD,4'hE}, {7'h03,7'h06,7'h06,7'h0E}, 4'hF);

    // suppression on from the next frame_start
    bus.value = 16'h0050; bus.lz_toggle = 1'b1;
    @(negedge clock); bus.lz_toggle = 1'b0;
    wait_fs(c);
    chk_frame("f_lz_0050", {4'hF,4'hF,4'hD,4'hE}, {7'h7F,7'h7F,7'h12,7'h40}, 4'h3);
    bus.value = 16'h0000;
    wait_fs(c);
    chk_frame("f_lz_0000", {4'hF,4'hF,4'hF,4'hE}, {7'h7F,7'h7F,7'h7F,7'h40}, 4'h1);

    // invalid snapshot blanks the whole frame; valid restores it
    bus.value = 16'h1234; bus.value_valid = 1'b0;
    wait_fs(c);
    bus.value_valid = 1'b1;
    chk_frame("f_invalid", {4'hF,4'hF,4'hF,4'hF}, {7'h7F,7'h7F,7'h7F,7'h7F}, 4'hF);
    wait_fs(c);
    chk_frame("f_restore", {4'h7,4'hB,4'hD,4'hE}, {7'h79,7'h24,7'h30,7'h19}, 4'hF);

    // toggle coincident with the snapshot edge: model checks the next two frames
    bus.value = 16'h0050;
    wait_fs(c);
    repeat (FRAME - 1) @(negedge clock);
    bus.lz_toggle = 1'b1;
    @(negedge clock); bus.lz_toggle = 1'b0;
    wait_fs(c);
    wait_fs(c);

    // async reset during digit 2
    bus.value = 16'h1234;
    wait_fs(c);
    c = 0;
    while (bus.an_n != 4'b1011 && c < 2 * FRAME) begin @(negedge clock); c++; end
    chk("digit2_reached", {12'h0, bus.an_n}, 16'h000B);
    @(posedge clock); #2 resetn = 1'b0;
    #1;
    chk("async_rst_an", {12'h0, bus.an_n}, 16'h000F);
    chk("async_rst_seg", {9'h0, bus.seg_n}, 16'h007F);
    chk("async_rst_fs", {15'h0, bus.frame_start}, 16'h0);
    repeat (2) @(negedge clock);
    #2 resetn = 1'b1;
    wait_fs(c);
    chk("post_rst_fs_latency", 16'(c), 16'(FRAME));

    // randomized traffic, occasional reset pulses
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      if ($urandom_range(3) == 0) bus.value = 16'($urandom);
      if ($urandom_range(15) == 0) bus.value = 16'($urandom_range(255)) << (4 * $urandom_range(2));
      bus.value_valid = ($urandom_range(4) != 0);
      bus.lz_toggle   = ($urandom_range(11) == 0);
      if ($urandom_range(399) == 0) begin
        #2 resetn = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        #2 resetn = 1'b1;
      end
    end
    bus.lz_toggle = 1'b0;
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
